// File: rtl/shot_capture_if.sv
// Signal bundle between the game controller / mouse side and shot_capture.
interface shot_capture_if;
  logic        left_clicked;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        enable;
  logic        shot_ack;
  logic        shot_valid;
  logic [11:0] shot_x;
  logic [11:0] shot_y;
  logic [2:0]  shot_zone;
  logic        shot_on_target;

  // Handshake: shot_valid rises together with stable shot_x/shot_y/shot_zone/shot_on_target
  // and stays high until shot_ack (or enable low) is sampled on a rising edge; it drops on
  // that edge, the data outputs keep their values, and shot_ack outside a valid shot is ignored.
  modport master (
    output left_clicked, xpos, ypos, enable, shot_ack,
    input  shot_valid, shot_x, shot_y, shot_zone, shot_on_target
  );
  modport slave (
    input  left_clicked, xpos, ypos, enable, shot_ack,
    output shot_valid, shot_x, shot_y, shot_zone, shot_on_target
  );
endinterface

// File: rtl/shot_capture.sv
// Debounces the left mouse button and latches one shot position, with its goal zone,
// per press; the shot is offered on a valid/ack handshake.
module shot_capture #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int X_MIN           = 212,
  parameter int X_MAX           = 811,
  parameter int Y_MIN           = 150,
  parameter int Y_MAX           = 349
) (
  input  logic           clk,
  input  logic           rst,
  shot_capture_if.slave  bus,
  output logic [1:0]     state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int COL_W = (X_MAX - X_MIN + 1) / 3;
  localparam int ROW_H = (Y_MAX - Y_MIN + 1) / 2;
  localparam logic [11:0] X_LO = 12'(X_MIN);
  localparam logic [11:0] X_HI = 12'(X_MAX);
  localparam logic [11:0] X_C1 = 12'(X_MIN + COL_W);
  localparam logic [11:0] X_C2 = 12'(X_MIN + 2 * COL_W);
  localparam logic [11:0] Y_LO = 12'(Y_MIN);
  localparam logic [11:0] Y_HI = 12'(Y_MAX);
  localparam logic [11:0] Y_R1 = 12'(Y_MIN + ROW_H);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESENT  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic          sync_q1;
  logic          sync_q2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          valid_q;
  logic [11:0]   x_q;
  logic [11:0]   y_q;
  logic [2:0]    zone_q;
  logic          on_q;

  logic          level;
  logic          on_tgt;
  logic [1:0]    col;
  logic          row;
  logic [2:0]    zone;

  assign level = sync_q2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bus.left_clicked;
      sync_q2 <= sync_q1;
    end
  end

  // Zone is evaluated every cycle and only captured on the accepting edge.
  always_comb begin
    on_tgt = (bus.xpos >= X_LO) && (bus.xpos <= X_HI) &&
             (bus.ypos >= Y_LO) && (bus.ypos <= Y_HI);
    if (bus.xpos < X_C1)      col = 2'd0;
    else if (bus.xpos < X_C2) col = 2'd1;
    else                      col = 2'd2;
    row  = (bus.ypos >= Y_R1);
    zone = on_tgt ? ((row ? 3'd3 : 3'd0) + {1'b0, col}) : 3'd7;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      zone_q  <= 3'd7;
      on_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (level && bus.enable) state <= S_DEBOUNCE;
        end
        S_DEBOUNCE: begin
          if (!level || !bus.enable) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_PRESENT;
            cnt     <= '0;
            valid_q <= 1'b1;
            x_q     <= bus.xpos;
            y_q     <= bus.ypos;
            zone_q  <= zone;
            on_q    <= on_tgt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRESENT: begin
          // Ack and an enable drop end the shot the same way; data stays latched.
          if (bus.shot_ack || !bus.enable) begin
            state   <= S_RELEASE;
            cnt     <= '0;
            valid_q <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.shot_valid     = valid_q;
  assign bus.shot_x         = x_q;
  assign bus.shot_y         = y_q;
  assign bus.shot_zone      = zone_q;
  assign bus.shot_on_target = on_q;
  assign state_dbg          = state;

endmodule

// File: doc/shot_capture.md
SHOT_CAPTURE -- requirements
Module: shot_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 65000, number of consecutive stable synchronized samples required for press or release (minimum 2).
REQ-002 SHALL have parameter X_MIN, default 212, left edge of goal area in pixels.
REQ-003 SHALL have parameter X_MAX, default 811, right edge of goal area in pixels.
REQ-004 SHALL have parameter Y_MIN, default 150, top edge of goal area in pixels.
REQ-005 SHALL have parameter Y_MAX, default 349, bottom edge of goal area in pixels.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  system clock (pixel clock domain); rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have the following ports, in addition to clk and rst:
- left_clicked  in  1  raw left-button level from the mouse controller, asynchronous.
- xpos  in  12  cursor x.
- ypos  in  12  cursor y.
- enable  in  1  game in shooting state; clicks are accepted only while high.
- shot_ack  in  1  consumer has taken the shot.
- shot_valid  out  1  captured shot available.
- shot_x  out  12  captured x.
- shot_y  out  12  captured y.
- shot_zone  out  3  goal zone 0..5, or 7 when off target.
- shot_on_target  out  1  captured point lies inside the goal area.

Function
REQ-008 SHALL pass left_clicked through a 2-flop synchronizer; all further logic uses only the synchronized level.
REQ-009 SHALL implement a four-state FSM: IDLE, DEBOUNCE, PRESENT, RELEASE.
REQ-010 IDLE: when synchronized level = 1 and enable = 1, go to DEBOUNCE with the counter cleared. Otherwise remain in IDLE.
REQ-011 DEBOUNCE: the counter increments each cycle that the level is 1. If the level = 0 or enable = 0, go to IDLE (no output). On the cycle the counter reaches DEBOUNCE_CYCLES-1, register xpos/ypos and the zone result, then go to PRESENT.
REQ-012 Latency: with left_clicked held high and enable high, shot_valid SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after left_clicked is first sampled high.
REQ-013 PRESENT: shot_valid = 1, and shot_x, shot_y, shot_zone and shot_on_target are held constant. If shot_ack = 1, shot_valid SHALL drop on the next edge and the FSM goes to RELEASE.
REQ-014 PRESENT with enable = 0 (and no ack): shot_valid drops on the next edge and the FSM goes to RELEASE (shot aborted). Data outputs retain their last values.
REQ-015 shot_ack and enable falling in the same cycle SHALL be treated as ack; the result is identical, with the FSM going to RELEASE.
REQ-016 shot_ack while not in PRESENT SHALL be ignored.
REQ-017 RELEASE: the counter increments each cycle that the level is 0 and clears to 0 when the level = 1. On reaching DEBOUNCE_CYCLES-1, go to IDLE. A button held continuously therefore produces exactly one shot.
REQ-018 Zone computation:
- COL_W = (X_MAX-X_MIN+1)/3 and ROW_H = (Y_MAX-Y_MIN+1)/2, both integer constants.
- col = 0 if x < X_MIN+COL_W; col = 1 if x < X_MIN+2*COL_W; otherwise col = 2.
- row = 0 if y < Y_MIN+ROW_H; otherwise row = 1.
- zone = row*3+col.
REQ-019 shot_on_target = 1 if and only if X_MIN<=x<=X_MAX and Y_MIN<=y<=Y_MAX (boundaries inclusive). When shot_on_target = 0, shot_zone = 7.
REQ-020 All comparisons SHALL be unsigned 12-bit. The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits and saturate, never wrapping.

Reset
REQ-021 While rst = 0, the block SHALL hold the FSM in IDLE and clear the counter, both synchronizer flops, shot_valid, shot_x, shot_y and shot_on_target to 0, and set shot_zone to 7.
REQ-022 Reset assertion SHALL take effect immediately and asynchronously, including mid-DEBOUNCE or mid-PRESENT.
REQ-023 After rst returns to 1, the block SHALL start in IDLE. A button already held high at that point is accepted as a new press.

Verification (DEBOUNCE_CYCLES=4, default bounds)
REQ-024 Click held at (300,200), enable = 1 -> shot_valid rises 7 edges after the press, shot_x = 300, shot_y = 200, zone = 0, on_target = 1. Ack -> shot_valid = 0 on the next edge.
REQ-025 Click held at (811,349) -> zone = 5, on_target = 1. Click held at (812,349) -> zone = 7, on_target = 0.
REQ-026 Bounce pattern 1,1,0,1,1,0 then steady 1 -> exactly one shot_valid pulse, timed from the final rising level. Button held 1000 cycles after ack -> no second shot.
REQ-027 enable = 0 while clicking -> shot_valid stays 0. enable falls during PRESENT -> shot_valid = 0 on the next edge, FSM in RELEASE, and a new click is accepted only after 4 release cycles.
REQ-028 rst = 0 asserted during PRESENT -> shot_valid, shot_x, shot_y = 0 and zone = 7 immediately. rst released with the button held -> new shot 7 edges later.
REQ-029 Simultaneous shot_ack and enable fall in PRESENT -> single deassertion, RELEASE entered, no glitch on the data outputs.
